seq_divider: RTL and testbench
==============================

# seq_divider

Iterative radix-2 integer divider for the RISC5 execute stage, the inverse companion to the sequential multiplier. Computes quotient and remainder of a dividend by a divisor, signed or unsigned, one quotient bit per clock. Uses the same run/stall handshake as the multiplier, so the ALU sequences DIV/MOD exactly as it does MUL.

## Interface
- WIDTH, 32, operand, quotient and remainder width.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  held high by the ALU for the whole operation; operands must be stable while high.
- op_unsigned  in  1  1 = unsigned division, 0 = signed Euclidean division; sampled with operands.
- stall  out  1  run & ~done; combinational.
- x  in  WIDTH  dividend.
- y  in  WIDTH  divisor.
- quot  out  WIDTH  quotient, registered.
- rem  out  WIDTH  remainder, registered.

## Operation
- State counter S, 0..WIDTH+2. S <= run ? S+1 : 0, saturating at WIDTH+2 while run stays high.
- S=0 (load): latch |x|, |y| (unsigned mode: raw values), sign of x, sign of y, op_unsigned, zero flag (y==0). Clear partial remainder.
- S=1..WIDTH (iterate): shift the {partial remainder, dividend} pair left by 1; trial subtract |y| on WIDTH+1 bits; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0.
- S=WIDTH+1 (fix-up): compute the final results from unsigned q0, r0 and register them into quot/rem. S then becomes WIDTH+2 = done.
- Unsigned: quot=q0, rem=r0.
- Signed Euclidean, 0 <= rem < |y|:
  - x>=0: q=q0, r=r0.
  - x<0, r0==0: q=-q0, r=0.
  - x<0, r0!=0: q=-(q0+1), r=|y|-r0.
  - If y<0, negate q afterwards.
- Divide by zero (either mode): quot = all ones, rem = x.
- Signed overflow (x = -2^(WIDTH-1), y = -1): quot = 0x80000000, rem = 0; two's-complement wrap, no flag.
- quot/rem hold their value until the next fix-up or reset; they are not cleared when run drops.

## Timing
- Reset: S=0, quot=0, rem=0; stall = run (combinational).
- With run rising in cycle 0, stall is high in cycles 0..WIDTH+1 (34 cycles at WIDTH=32) and low from cycle WIDTH+2. quot/rem are valid in that cycle and are held while run stays high.
- run dropped before done: abort; S <= 0 at the next edge; quot/rem keep their previous values. A new run restarts from load.
- run low for a single cycle between operations is sufficient to restart.
- rst high takes priority over run in the same cycle.
- Operand changes after load are ignored until the next load.

## Configuration
- SEQ_DIVIDER_ZERO_FAST_EN defined: a zero divisor detected at load jumps S directly to WIDTH+1 (fix-up). stall is high for 2 cycles instead of WIDTH+2, and results are the same divide-by-zero values.
- Undefined: latency is fixed at WIDTH+2 for all operands.

## Test plan
- Unsigned x=100, y=7, run held -> stall high exactly 34 cycles; then quot=14, rem=2.
- Signed x=-7, y=2 -> quot=0xFFFFFFFC (-4), rem=1. Signed x=7, y=-2 -> quot=0xFFFFFFFD (-3), rem=1. Signed x=-7, y=-2 -> quot=4, rem=1.
- Unsigned x=0xFFFFFFFF, y=1 -> quot=0xFFFFFFFF, rem=0. Signed x=0x80000000, y=0xFFFFFFFF -> quot=0x80000000, rem=0.
- y=0, x=0x1234 (both modes) -> quot=0xFFFFFFFF, rem=0x1234. Stall is 34 cycles without the macro and 2 cycles with SEQ_DIVIDER_ZERO_FAST_EN.
- Start 100/7, drop run at cycle 10, start 9/3 -> 34 fresh stall cycles, then quot=3, rem=0. Repeat with rst asserted at cycle 10 -> S=0, quot=rem=0.
- Back-to-back: two operations separated by one run-low cycle -> each yields correct results; the previous results stay visible during the second operation's stall.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative radix-2 signed/unsigned divider with run/stall handshake, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor skips the iterations and goes straight to fix-up.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             op_unsigned,
    output logic             stall,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int SW = $clog2(WIDTH + 3);
    localparam logic [SW-1:0] S_LOAD = '0;
    localparam logic [SW-1:0] S_LAST = SW'(WIDTH);
    localparam logic [SW-1:0] S_FIX  = SW'(WIDTH + 1);
    localparam logic [SW-1:0] S_DONE = SW'(WIDTH + 2);

    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pr_q, pr_d;     // partial remainder
    logic [WIDTH-1:0] dq_q, dq_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] ay_q, ay_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             sx_q, sx_d, sy_q, sy_d, uns_q, uns_d, dz_q, dz_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;

    logic             x_neg, y_neg;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] q_t, r_t;

    assign stall = run & (cnt_q != S_DONE);
    assign quot  = quot_q;
    assign rem   = rem_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q;
        pr_d   = pr_q;
        dq_d   = dq_q;
        ay_d   = ay_q;
        x_d    = x_q;
        sx_d   = sx_q;
        sy_d   = sy_q;
        uns_d  = uns_q;
        dz_d   = dz_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        q_t    = '0;
        r_t    = '0;

        x_neg   = ~op_unsigned & x[WIDTH-1];
        y_neg   = ~op_unsigned & y[WIDTH-1];
        shifted = {pr_q, dq_q[WIDTH-1]};
        diff    = shifted - {1'b0, ay_q};

        if (!run) begin
            cnt_d = S_LOAD;
        end else if (cnt_q == S_DONE) begin
            cnt_d = S_DONE;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
        end else if (cnt_q == S_LOAD && y == '0) begin
            cnt_d = S_FIX;
`endif
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (run) begin
            if (cnt_q == S_LOAD) begin
                pr_d  = '0;
                dq_d  = x_neg ? -x : x;
                ay_d  = y_neg ? -y : y;
                x_d   = x;
                sx_d  = x_neg;
                sy_d  = y_neg;
                uns_d = op_unsigned;
                dz_d  = (y == '0);
            end else if (cnt_q <= S_LAST) begin
                // Invariant pr_q < ay_q keeps the sign of a WIDTH+1 bit difference exact.
                pr_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                dq_d = {dq_q[WIDTH-2:0], ~diff[WIDTH]};
            end else if (cnt_q == S_FIX) begin
                if (dz_q) begin
                    quot_d = '1;
                    rem_d  = x_q;
                end else if (uns_q) begin
                    quot_d = dq_q;
                    rem_d  = pr_q;
                end else begin
                    // Euclidean: round the quotient so the remainder lands in [0, |y|).
                    if (!sx_q) begin
                        q_t = dq_q;
                        r_t = pr_q;
                    end else if (pr_q == '0) begin
                        q_t = -dq_q;
                        r_t = '0;
                    end else begin
                        q_t = ~dq_q;
                        r_t = ay_q - pr_q;
                    end
                    quot_d = sy_q ? -q_t : q_t;
                    rem_d  = r_t;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= S_LOAD;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    // NOTE: operand/datapath registers are always rewritten at load, so they need no reset.
    always_ff @(posedge clk) begin
        pr_q  <= pr_d;
        dq_q  <= dq_d;
        ay_q  <= ay_d;
        x_q   <= x_d;
        sx_q  <= sx_d;
        sy_q  <= sy_d;
        uns_q <= uns_d;
        dz_q  <= dz_d;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, abort/reset sequences and
// randomized operations compared against an arithmetic Euclidean-division model.
module tb_seq_divider;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, run, op_unsigned, stall;
    logic [W-1:0]  x, y, quot, rem;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .run(run), .op_unsigned(op_unsigned), .stall(stall),
        .x(x), .y(y), .quot(quot), .rem(rem)
    );

    typedef struct {
        logic         uns;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division then Euclidean adjustment.
    function automatic void model(input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            if (lr < 0) begin
                if (sb > 0) lq = lq - 1;
                else        lq = lq + 1;
                lr = lr + ((sb > 0) ? sb : -sb);
            end
            q = lq[W-1:0];
            r = lr[W-1:0];
        end
    endfunction

    function automatic int exp_stall(input logic [W-1:0] b);
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
        if (b == '0) return 2;
`endif
        return W + 2;
    endfunction

    // Raise run with operands, count stall cycles (bounded), return results; run stays high.
    task automatic run_op(input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit scramble, output int stalls,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic [W-1:0] mid_q, output logic [W-1:0] mid_r);
        @(negedge clk);
        op_unsigned = uns;
        x = a;
        y = b;
        run = 1'b1;
        stalls = 0;
        mid_q = quot;
        mid_r = rem;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (c == 1) begin
                mid_q = quot;
                mid_r = rem;
            end
            if (!stall) break;
            stalls++;
            @(negedge clk);
            if (scramble) begin
                x = $urandom;
                y = $urandom;
                op_unsigned = 1'($urandom);
            end
        end
        q = quot;
        r = rem;
    endtask

    task automatic drop_run();
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic do_op(input string name, input logic uns, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit scramble,
                         input bit chk_prev, input logic [W-1:0] pq, input logic [W-1:0] pr);
        int stalls;
        logic [W-1:0] q, r, mq, mr, eq, er;
        model(uns, a, b, eq, er);
        run_op(uns, a, b, scramble, stalls, q, r, mq, mr);
        check({name, " stall"}, W'(stalls), W'(exp_stall(b)));
        check({name, " quot"}, q, eq);
        check({name, " rem"}, r, er);
        if (chk_prev) begin
            check({name, " prev quot held"}, mq, pq);
            check({name, " prev rem held"}, mr, pr);
        end
    endtask

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pq, pr, a, b, eq, er;
        logic         uns;
        int           stalls;

        vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b0, -32'sd7,        32'd2,          32'hFFFFFFFC,   32'd1};
        vecs[2]  = '{1'b0, 32'd7,          -32'sd2,        32'hFFFFFFFD,   32'd1};
        vecs[3]  = '{1'b0, -32'sd7,        -32'sd2,        32'd4,          32'd1};
        vecs[4]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[6]  = '{1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234};
        vecs[7]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234};
        vecs[8]  = '{1'b0, -32'sd8,        32'd2,          32'hFFFFFFFC,   32'd0};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF};
        vecs[10] = '{1'b1, 32'd5,          32'd9,          32'd0,          32'd5};
        vecs[11] = '{1'b1, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF};

        rst = 1'b1;
        run = 1'b0;
        op_unsigned = 1'b0;
        x = '0;
        y = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset quot", quot, '0);
        check("reset rem", rem, '0);
        check("reset stall run low", W'(stall), 32'd0);
        run = 1'b1;
        #1;
        check("reset stall run high", W'(stall), 32'd1);
        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;

        pq = '0;
        pr = '0;
        for (int i = 0; i < 12; i++) begin
            int s;
            logic [W-1:0] q, r, mq, mr;
            run_op(vecs[i].uns, vecs[i].a, vecs[i].b, 1'b0, s, q, r, mq, mr);
            check($sformatf("vec%0d stall", i), W'(s), W'(exp_stall(vecs[i].b)));
            check($sformatf("vec%0d quot", i), q, vecs[i].q);
            check($sformatf("vec%0d rem", i), r, vecs[i].r);
            check($sformatf("vec%0d prev quot", i), mq, pq);
            repeat (3) @(negedge clk);
            #1;
            check($sformatf("vec%0d hold quot", i), quot, vecs[i].q);
            check($sformatf("vec%0d hold stall", i), W'(stall), 32'd0);
            pq = vecs[i].q;
            pr = vecs[i].r;
            drop_run();
        end

        // Abort at cycle 10, then a fresh 9/3 after a single idle cycle.
        @(negedge clk);
        op_unsigned = 1'b1; x = 32'd100; y = 32'd7; run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        #1;
        check("abort stall low", W'(stall), 32'd0);
        check("abort quot kept", quot, pq);
        check("abort rem kept", rem, pr);
        do_op("restart 9/3", 1'b1, 32'd9, 32'd3, 1'b0, 1'b1, pq, pr);
        drop_run();

        // Reset at cycle 10 with run still high: reset wins, then a full operation follows.
        @(negedge clk);
        op_unsigned = 1'b1; x = 32'd100; y = 32'd7; run = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst quot", quot, '0);
        check("midrst rem", rem, '0);
        stalls = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) #1;
            if (!stall) break;
            stalls++;
            @(negedge clk);
        end
        check("midrst stall", W'(stalls), 32'd34);
        check("midrst quot after", quot, 32'd14);
        check("midrst rem after", rem, 32'd2);
        drop_run();
        pq = 32'd14;
        pr = 32'd2;

        // Randomized operations with special operands mixed in and operands scrambled after load.
        for (int i = 0; i < 30; i++) begin
            uns = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'd1;
                2: b = 32'hFFFFFFFF;
                3: a = 32'h80000000;
                4: b = W'($urandom_range(1, 300));
                5: b = 32'h80000000;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), uns, a, b, 1'b1, 1'b1, pq, pr);
            model(uns, a, b, eq, er);
            pq = eq;
            pr = er;
            drop_run();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
